// File: rtl/det_4x4_seq.sv
// det_4x4_seq: sequential 4x4 signed determinant using a single shared multiplier.
// Rows 3-4 give six 2x2 minors, row 2 folds them into four 3x3 cofactor minors,
// and row 1 combines those into the final determinant. The whole job takes 28 cycles.
module det_4x4_seq #(
    parameter int ACC_W = 40
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [127:0]            A,
    input  logic                    abort,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              det,
    output logic signed [ACC_W-1:0] det_full,
    output logic                    overflow_flag,
    output logic                    busy
);

    localparam int MIN_W = 17;  // |2x2 minor| <= 2*128*128
    localparam int COF_W = 27;  // |3x3 minor| <= 3*128*2^15

    // Entry indices in row-major order: rows (a b c d)(e f g h)(i j k l)(m n o p).
    localparam int EA = 0,  EB = 1,  EC = 2,  ED = 3;
    localparam int EE = 4,  EF = 5,  EG = 6,  EH = 7;
    localparam int EI = 8,  EJ = 9,  EK = 10, EL = 11;
    localparam int EM = 12, EN = 13, EO = 14, EP = 15;

    typedef enum logic [2:0] {S_IDLE, S_MIN2, S_MIN3, S_FINAL, S_DONE} state_t;
    typedef enum logic [1:0] {DST_NONE, DST_MIN, DST_COF, DST_DET} dst_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [4:0]                r_step;
    logic [127:0]              r_mat;
    logic signed [MIN_W-1:0]   r_minor [6];
    logic signed [COF_W-1:0]   r_cof   [4];
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [ACC_W-1:0]   r_det_full;
    logic                      r_ovf;

    logic signed [7:0]         w_e [16];
    logic signed [7:0]         w_op8;
    logic signed [ACC_W-1:0]   w_opw;
    logic                      w_neg;
    logic                      w_first;
    dst_t                      w_dst;
    logic [2:0]                w_idx;
    logic signed [ACC_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]   w_base;
    logic signed [ACC_W-1:0]   w_sum;
    logic                      w_ovf;
    logic                      w_accept;
    logic                      w_compute;
    logic                      w_abort_now;

    function automatic logic signed [ACC_W-1:0] sx8(input logic signed [7:0] x);
        return {{(ACC_W-8){x[7]}}, x};
    endfunction

    function automatic logic signed [ACC_W-1:0] sxm(input logic signed [MIN_W-1:0] x);
        return {{(ACC_W-MIN_W){x[MIN_W-1]}}, x};
    endfunction

    function automatic logic signed [ACC_W-1:0] sxc(input logic signed [COF_W-1:0] x);
        return {{(ACC_W-COF_W){x[COF_W-1]}}, x};
    endfunction

    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_compute   = (r_state == S_MIN2) || (r_state == S_MIN3) || (r_state == S_FINAL);
    assign w_abort_now = abort && w_compute;

    // Split the captured matrix into its sixteen signed entries.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            w_e[k] = r_mat[127-8*k -: 8];
        end
    end

    // Per-step schedule: operands, sign of the term, start of a new sum, and destination.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no step leaves a latch behind.
        w_op8   = '0;
        w_opw   = '0;
        w_neg   = 1'b0;
        w_first = 1'b0;
        w_dst   = DST_NONE;
        w_idx   = '0;
        case (r_step)
            // 2x2 minors of rows 3-4
            5'd0 : begin w_op8 = w_e[EJ]; w_opw = sx8(w_e[EO]); w_first = 1'b1; end
            5'd1 : begin w_op8 = w_e[EK]; w_opw = sx8(w_e[EN]); w_neg = 1'b1; w_dst = DST_MIN; w_idx = 3'd0; end
            5'd2 : begin w_op8 = w_e[EJ]; w_opw = sx8(w_e[EP]); w_first = 1'b1; end
            5'd3 : begin w_op8 = w_e[EL]; w_opw = sx8(w_e[EN]); w_neg = 1'b1; w_dst = DST_MIN; w_idx = 3'd1; end
            5'd4 : begin w_op8 = w_e[EK]; w_opw = sx8(w_e[EP]); w_first = 1'b1; end
            5'd5 : begin w_op8 = w_e[EL]; w_opw = sx8(w_e[EO]); w_neg = 1'b1; w_dst = DST_MIN; w_idx = 3'd2; end
            5'd6 : begin w_op8 = w_e[EI]; w_opw = sx8(w_e[EO]); w_first = 1'b1; end
            5'd7 : begin w_op8 = w_e[EK]; w_opw = sx8(w_e[EM]); w_neg = 1'b1; w_dst = DST_MIN; w_idx = 3'd3; end
            5'd8 : begin w_op8 = w_e[EI]; w_opw = sx8(w_e[EP]); w_first = 1'b1; end
            5'd9 : begin w_op8 = w_e[EL]; w_opw = sx8(w_e[EM]); w_neg = 1'b1; w_dst = DST_MIN; w_idx = 3'd4; end
            5'd10: begin w_op8 = w_e[EI]; w_opw = sx8(w_e[EN]); w_first = 1'b1; end
            5'd11: begin w_op8 = w_e[EJ]; w_opw = sx8(w_e[EM]); w_neg = 1'b1; w_dst = DST_MIN; w_idx = 3'd5; end
            // 3x3 cofactor minors: M1 = f*m2 - g*m1 + h*m0, M2 = e*m2 - g*m4 + h*m3,
            // M3 = e*m1 - f*m4 + h*m5, M4 = e*m0 - f*m3 + g*m5
            5'd12: begin w_op8 = w_e[EF]; w_opw = sxm(r_minor[2]); w_first = 1'b1; end
            5'd13: begin w_op8 = w_e[EG]; w_opw = sxm(r_minor[1]); w_neg = 1'b1; end
            5'd14: begin w_op8 = w_e[EH]; w_opw = sxm(r_minor[0]); w_dst = DST_COF; w_idx = 3'd0; end
            5'd15: begin w_op8 = w_e[EE]; w_opw = sxm(r_minor[2]); w_first = 1'b1; end
            5'd16: begin w_op8 = w_e[EG]; w_opw = sxm(r_minor[4]); w_neg = 1'b1; end
            5'd17: begin w_op8 = w_e[EH]; w_opw = sxm(r_minor[3]); w_dst = DST_COF; w_idx = 3'd1; end
            5'd18: begin w_op8 = w_e[EE]; w_opw = sxm(r_minor[1]); w_first = 1'b1; end
            5'd19: begin w_op8 = w_e[EF]; w_opw = sxm(r_minor[4]); w_neg = 1'b1; end
            5'd20: begin w_op8 = w_e[EH]; w_opw = sxm(r_minor[5]); w_dst = DST_COF; w_idx = 3'd2; end
            5'd21: begin w_op8 = w_e[EE]; w_opw = sxm(r_minor[0]); w_first = 1'b1; end
            5'd22: begin w_op8 = w_e[EF]; w_opw = sxm(r_minor[3]); w_neg = 1'b1; end
            5'd23: begin w_op8 = w_e[EG]; w_opw = sxm(r_minor[5]); w_dst = DST_COF; w_idx = 3'd3; end
            // Final expansion along row 1: a*M1 - b*M2 + c*M3 - d*M4
            5'd24: begin w_op8 = w_e[EA]; w_opw = sxc(r_cof[0]); w_first = 1'b1; end
            5'd25: begin w_op8 = w_e[EB]; w_opw = sxc(r_cof[1]); w_neg = 1'b1; end
            5'd26: begin w_op8 = w_e[EC]; w_opw = sxc(r_cof[2]); end
            5'd27: begin w_op8 = w_e[ED]; w_opw = sxc(r_cof[3]); w_neg = 1'b1; w_dst = DST_DET; end
            default: ;
        endcase
    end

    // The single shared multiplier and the running signed accumulation.
    assign w_prod = sx8(w_op8) * w_opw;
    assign w_base = w_first ? '0 : r_acc;
    assign w_sum  = w_neg ? (w_base - w_prod) : (w_base + w_prod);
    // Outside -128..127 exactly when the bits above bit 6 are not a pure sign extension.
    assign w_ovf  = ~((&w_sum[ACC_W-1:7]) | ~(|w_sum[ACC_W-1:7]));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated only with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort beats the normal advance in every compute state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)              w_next = S_MIN2;
            S_MIN2:  if (abort)                 w_next = S_IDLE;
                     else if (r_step == 5'd11)  w_next = S_MIN3;
            S_MIN3:  if (abort)                 w_next = S_IDLE;
                     else if (r_step == 5'd23)  w_next = S_FINAL;
            S_FINAL: if (abort)                 w_next = S_IDLE;
                     else if (r_step == 5'd27)  w_next = S_DONE;
            S_DONE:  if (out_ready)             w_next = S_IDLE;
            default:                            w_next = S_IDLE;
        endcase
    end

    // Step counter and the visible result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step     <= '0;
            r_det_full <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_accept || w_abort_now) begin
                r_step <= '0;
            end else if (w_compute) begin
                r_step <= r_step + 5'd1;
            end
            if (w_compute && !abort && (w_dst == DST_DET)) begin
                r_det_full <= w_sum;
                r_ovf      <= w_ovf;
            end
        end
    end

    // Datapath storage: matrix capture, accumulator and intermediate minors.
    always_ff @(posedge clk) begin
        // NOTE: these registers carry no reset; each is written before it is read within a job.
        if (w_accept) begin
            r_mat <= A;
        end
        if (w_compute) begin
            r_acc <= w_sum;
            if (w_dst == DST_MIN) begin
                r_minor[w_idx] <= w_sum[MIN_W-1:0];
            end else if (w_dst == DST_COF) begin
                r_cof[w_idx[1:0]] <= w_sum[COF_W-1:0];
            end
        end
    end

    assign in_ready      = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign out_valid     = (r_state == S_DONE);
    assign det_full      = r_det_full;
    assign det           = r_det_full[7:0];
    assign overflow_flag = r_ovf;

endmodule

// File: tb/tb_det_4x4_seq.sv
// Bench for det_4x4_seq: directed matrices with hand-computed determinants, a
// scoreboard queue filled at acceptance and drained by an independent monitor.
module tb_det_4x4_seq;

    localparam int ACC_W = 40;
    localparam int LAT   = 28;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [127:0]            A;
    logic                    abort;
    logic                    out_valid;
    logic                    out_ready;
    logic [7:0]              det;
    logic signed [ACC_W-1:0] det_full;
    logic                    overflow_flag;
    logic                    busy;

    always #5 clk = ~clk;

    det_4x4_seq #(.ACC_W(ACC_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .A             (A),
        .abort         (abort),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .det           (det),
        .det_full      (det_full),
        .overflow_flag (overflow_flag),
        .busy          (busy)
    );

    typedef struct {
        logic signed [63:0] full;
        logic               ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] pack(input int m[16]);
        logic [127:0] v;
        for (int k = 0; k < 16; k++) begin
            v[127-8*k -: 8] = m[k][7:0];
        end
        return v;
    endfunction

    // Leibniz-formula reference over all 24 permutations, in 64-bit arithmetic.
    function automatic longint golden(input int m[16]);
        longint s = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 4; k++)
                    for (int l = 0; l < 4; l++) begin
                        if (i != j && i != k && i != l && j != k && j != l && k != l) begin
                            int inv = 0;
                            longint t;
                            if (i > j) inv++;
                            if (i > k) inv++;
                            if (i > l) inv++;
                            if (j > k) inv++;
                            if (j > l) inv++;
                            if (k > l) inv++;
                            t = longint'(m[i]) * longint'(m[4+j]) * longint'(m[8+k]) * longint'(m[12+l]);
                            s = (inv % 2 == 1) ? s - t : s + t;
                        end
                    end
        return s;
    endfunction

    // Monitor: compare against the scoreboard on every output handshake.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic signed [63:0] act_full;
        if (rst_n && out_valid && out_ready) begin
            act_full = det_full;
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: out_valid with det_full=%0d but no job outstanding", act_full);
            end else begin
                e = sb.pop_front();
                check("det_full", act_full, e.full);
                check("det", det, e.full[7:0]);
                check("overflow_flag", overflow_flag, e.ovf);
            end
        end
    end

    // Offer a matrix and return #1 after the accepting edge.
    task automatic accept(input logic [127:0] mat);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, n);
        end
        A        = mat;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic push(input longint full, input logic ovf);
        exp_t e;
        e.full = full;
        e.ovf  = ovf;
        sb.push_back(e);
    endtask

    // Count edges from acceptance until out_valid rises.
    task automatic wait_result();
        int lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, LAT);
    endtask

    // Full job with out_ready held high, then check the block is ready again.
    task automatic run_job(input logic [127:0] mat, input longint full, input logic ovf);
        accept(mat);
        push(full, ovf);
        wait_result();
        @(posedge clk); #1;
        check("in_ready_after_handshake", in_ready, 1);
        check("out_valid_after_handshake", out_valid, 0);
    endtask

    // Watch for any out_valid over a window; none should appear.
    task automatic expect_quiet(input string name, input int cycles);
        int seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check(name, seen, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int m[16];
        logic [127:0] mat_id;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        A         = '0;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_det_full", det_full, 0);
        check("rst_det", det, 0);
        check("rst_overflow", overflow_flag, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);

        // Identity, accepted on the first edge after release: det = 1
        m = '{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1};
        mat_id = pack(m);
        run_job(mat_id, 1, 1'b0);

        // diag(4,4,4,4): 256 -> det 0x00, overflow
        m = '{4,0,0,0, 0,4,0,0, 0,0,4,0, 0,0,0,4};
        run_job(pack(m), 256, 1'b1);

        // diag(-1,1,1,1): -1 -> det 0xFF, no overflow
        m = '{-1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1};
        run_job(pack(m), -1, 1'b0);

        // 127 on the diagonal, -128 elsewhere: 255^3 * (255 - 4*128) = -4261413375
        m = '{ 127,-128,-128,-128,
              -128, 127,-128,-128,
              -128,-128, 127,-128,
              -128,-128,-128, 127};
        run_job(pack(m), golden(m), 1'b1);

        // Rows 1 and 3 identical -> 0; out_ready low, in_valid and abort noise ignored
        m = '{1,2,3,4, 5,-6,7,8, 1,2,3,4, 9,10,-11,12};
        out_ready = 1'b0;
        accept(pack(m));
        push(0, 1'b0);
        m = '{7,1,0,0, 0,7,0,0, 0,0,7,0, 0,0,0,7};
        A        = pack(m);
        in_valid = 1'b1;
        wait_result();
        for (int c = 0; c < 10; c++) begin
            abort = (c % 2 == 0);
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_det_full", det_full, 0);
            check("hold_overflow", overflow_flag, 0);
            check("hold_in_ready", in_ready, 0);
        end
        abort     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_hold", in_ready, 1);

        // Lower triangular, -128 diagonal: (-128)^4 = 2^28 -> det 0x00, overflow
        m = '{-128,0,0,0, 5,-128,0,0, 127,-1,-128,0, -128,-128,-128,-128};
        run_job(pack(m), 268435456, 1'b1);

        // Upper triangular, diagonal (2,-3,5,-7): 210 -> det 0xD2, overflow
        m = '{2,7,-9,100, 0,-3,55,-128, 0,0,5,17, 0,0,0,-7};
        run_job(pack(m), 210, 1'b1);

        // Abort on cycle 15 of a job: no result, previous 210 retained
        m = '{3,0,0,0, 0,3,0,0, 0,0,3,0, 0,0,0,3};
        accept(pack(m));
        repeat (14) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_keep_det_full", det_full, 210);
        check("abort_keep_det", det, 8'hD2);
        check("abort_keep_overflow", overflow_flag, 1);
        expect_quiet("abort_no_out_valid", 40);

        // Next job after abort: 3*4*(2*5-1*1) = 108
        m = '{2,0,0,1, 0,3,0,0, 0,0,4,0, 1,0,0,5};
        run_job(pack(m), 108, 1'b0);

        // Reset on cycle 20 of a job: outputs clear at once, job discarded
        m = '{2,0,0,0, 0,2,0,0, 0,0,2,0, 0,0,0,2};
        accept(pack(m));
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_det_full", det_full, 0);
        check("midrst_det", det, 0);
        check("midrst_overflow", overflow_flag, 0);
        check("midrst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_in_ready", in_ready, 1);
        expect_quiet("reset_no_out_valid", 40);

        // Normal operation after the reset
        run_job(mat_id, 1, 1'b0);

        repeat (2) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
